// File: rtl/tiny16_alu_pkg.sv
// Shared definitions for the tiny16 ALU and its request arbiter.
//   - opcode constants for the nine legal ALU operations
//   - bit positions of the {O,C,N,Z} flag word
//   - arbiter state encoding
//   - op_rejected(): requests the arbiter answers itself, without the ALU
package tiny16_alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_MUL = 4'd5;
    localparam logic [3:0] OP_DIV = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_OR  = 4'd8;
    localparam logic [3:0] OP_XOR = 4'd9;
    localparam logic [3:0] OP_SHL = 4'd10;
    localparam logic [3:0] OP_SHR = 4'd11;

    localparam int unsigned FLG_O = 3;
    localparam int unsigned FLG_C = 2;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_Z = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_OUTEN = 3'd2,
        ST_CAPT  = 3'd3,
        ST_RESP  = 3'd4
    } arb_state_t;

    // Illegal opcodes and divide-by-zero never reach the ALU.
    function automatic logic op_rejected(input logic [3:0] op, input logic [15:0] src2);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND,
            OP_OR, OP_XOR, OP_SHL, OP_SHR: legal = 1'b1;
            default:                       legal = 1'b0;
        endcase
        return !legal || ((op == OP_DIV) && (src2 == '0));
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NREQ requesters and alu_arbiter.
//   req_valid/req_ready : per-requester handshake (req_ready one-hot)
//   req_opcode/req_ar/req_src1/req_src2 : packed per-requester fields,
//                         requester i at [4i+3:4i] / [i] / [16i+15:16i]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_result/rsp_flags/rsp_err : tagged response payload
// master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [4*NREQ-1:0]  req_opcode;
    logic [NREQ-1:0]    req_ar;
    logic [16*NREQ-1:0] req_src1;
    logic [16*NREQ-1:0] req_src2;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [15:0]        rsp_result;
    logic [3:0]         rsp_flags;
    logic               rsp_err;

    modport master (
        output req_valid, req_opcode, req_ar, req_src1, req_src2, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
    );

    modport slave (
        input  req_valid, req_opcode, req_ar, req_src1, req_src2, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
    );
endinterface

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
//   req       : request vector
//   last      : index granted most recently; search starts at last+1
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : index of the granted requester
//   grant_any : at least one request present
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    int unsigned    cand;
    logic [IDW-1:0] cand_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        // k = NREQ lands back on 'last' itself, so it is considered last.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand     = (32'(last) + k) % NREQ;
            cand_idx = IDW'(cand);
            if (!grant_any && req[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
                grant_any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one tiny16 ALU among NREQ requesters.
//   clk, rst     : clock; synchronous active-high reset (also resets the ALU)
//   arb (slave)  : request/response bundle, see alu_arbiter_if
//   alu_opcode, alu_ar_flag, alu_src1, alu_src2, alu_out_en : to the ALU
//   alu_out, alu_flags : from the ALU
// Flow: IDLE (grant + register operands) -> ISSUE (ALU computes) ->
// OUTEN (ALU publishes out/flags) -> CAPT (capture) -> RESP (hold until
// accepted). Rejected requests jump from IDLE straight to RESP.
module alu_arbiter
    import tiny16_alu_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic        clk,
    input  logic        rst,
    alu_arbiter_if.slave arb,
    output logic [3:0]  alu_opcode,
    output logic        alu_ar_flag,
    output logic [15:0] alu_src1,
    output logic [15:0] alu_src2,
    output logic        alu_out_en,
    input  logic [15:0] alu_out,
    input  logic [3:0]  alu_flags
);

    arb_state_t state_q, state_d;

    logic [IDW-1:0]  rr_last;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic [NREQ-1:0] req_ready;

    logic [3:0]      sel_op;
    logic            sel_ar;
    logic [15:0]     sel_src1;
    logic [15:0]     sel_src2;
    logic            sel_reject;

    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [15:0]     rsp_result_q;
    logic [3:0]      rsp_flags_q;
    logic            rsp_err_q;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req       (arb.req_valid),
        .last      (rr_last),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        alu_out_en = 1'b0;
        sel_op     = '0;
        sel_ar     = 1'b0;
        sel_src1   = '0;
        sel_src2   = '0;

        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_op   = arb.req_opcode[4*i +: 4];
                sel_ar   = arb.req_ar[i];
                sel_src1 = arb.req_src1[16*i +: 16];
                sel_src2 = arb.req_src2[16*i +: 16];
            end
        end
        sel_reject = op_rejected(sel_op, sel_src2);

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    req_ready = grant;
                    state_d   = sel_reject ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_OUTEN;
            ST_OUTEN: begin
                // Operands must stay put: the ALU derives overflow from
                // src1/src2 on the out_en edge.
                alu_out_en = 1'b1;
                state_d    = ST_CAPT;
            end
            ST_CAPT:  state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_valid_q && arb.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // rr_last doubles as the id of the transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last      <= IDW'(NREQ - 1);
            alu_opcode   <= '0;
            alu_ar_flag  <= 1'b0;
            alu_src1     <= '0;
            alu_src2     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        rr_last <= grant_idx;
                        if (sel_reject) begin
                            alu_opcode   <= '0;
                            alu_ar_flag  <= 1'b0;
                            alu_src1     <= '0;
                            alu_src2     <= '0;
                            rsp_valid_q  <= 1'b1;
                            rsp_id_q     <= grant_idx;
                            rsp_result_q <= '0;
                            rsp_flags_q  <= '0;
                            rsp_err_q    <= 1'b1;
                        end else begin
                            alu_opcode   <= sel_op;
                            alu_ar_flag  <= sel_ar;
                            alu_src1     <= sel_src1;
                            alu_src2     <= sel_src2;
                        end
                    end
                end
                ST_CAPT: begin
                    rsp_valid_q  <= 1'b1;
                    rsp_id_q     <= rr_last;
                    rsp_result_q <= alu_out;
                    rsp_flags_q  <= {alu_flags[FLG_O], alu_flags[FLG_C],
                                     alu_flags[FLG_N], alu_flags[FLG_Z]};
                    rsp_err_q    <= 1'b0;
                end
                ST_RESP: begin
                    if (rsp_valid_q && arb.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign arb.req_ready  = req_ready;
    assign arb.rsp_valid  = rsp_valid_q;
    assign arb.rsp_id     = rsp_id_q;
    assign arb.rsp_result = rsp_result_q;
    assign arb.rsp_flags  = rsp_flags_q;
    assign arb.rsp_err    = rsp_err_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one tiny16 `alu` instance among NREQ requesters using round-robin arbitration.
- Each request is accepted with a valid/ready handshake and registered.
- The block sequences the ALU's two-edge protocol: operand/compute edge, then out_en edge.
- It captures out/flags and returns a tagged response. It also screens illegal opcodes and divide-by-zero without using the ALU.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of requester id.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high; shared with the alu instance.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  one-hot accept, combinational, IDLE state only.
- req_opcode  in  4*NREQ  packed opcodes, requester i at [4i+3:4i].
- req_ar  in  NREQ  arithmetic/rotate flag per requester.
- req_src1  in  16*NREQ  packed operand 1.
- req_src2  in  16*NREQ  packed operand 2.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_id  out  IDW  requester index of the response.
- rsp_result  out  16  ALU result.
- rsp_flags  out  4  {O,C,N,Z}.
- rsp_err  out  1  request rejected (illegal opcode or divide by zero).
- alu_opcode  out  4  to alu.opcode.
- alu_ar_flag  out  1  to alu.ar_flag.
- alu_src1  out  16  to alu.src1.
- alu_src2  out  16  to alu.src2.
- alu_out_en  out  1  to alu.out_en.
- alu_out  in  16  from alu.out.
- alu_flags  in  4  from alu.flags.

Behaviour:
- States: IDLE, ISSUE, OUTEN, CAPT, RESP.
- Reset values:
  - state=IDLE; rr_last=NREQ-1, so requester 0 wins first.
  - rsp_valid=0; rsp_id, rsp_result, rsp_flags, rsp_err all 0.
  - alu_opcode=0, alu_ar_flag=0, alu_src1=0, alu_src2=0, alu_out_en=0.
- Reset mid-operation: abort, no response emitted, pending request dropped.
- IDLE:
  - Winner is the first req_valid found scanning from rr_last+1 with wrap-around.
  - req_ready[winner]=1 in the same cycle; handshake completes on that edge.
  - The winner's opcode/ar/src1/src2 are registered onto the alu_* outputs. rr_last becomes the winner.
  - req_ready is all-zero in every other state and when no request is valid.
- Legal opcodes: 3..11 (ADD, SUB, MUL, DIV, AND, OR, XOR, SHL, SHR).
  - Opcode outside 3..11, or DIV with src2==0, goes straight to RESP on the handshake edge.
  - Such a response has rsp_err=1, rsp_result=0, rsp_flags=0 and rsp_valid=1. The alu_* outputs are driven to 0.
- ISSUE: alu_* operands held, alu_out_en=0. At the next edge the ALU computes its result; go to OUTEN.
- OUTEN:
  - alu_out_en=1; operands held unchanged, because the ALU derives the overflow flag from src1/src2 on this edge.
  - Next edge: ALU updates out/flags; go to CAPT.
- CAPT:
  - alu_out_en=0. alu_out/alu_flags are valid this cycle.
  - On the edge: rsp_result<=alu_out, rsp_flags<=alu_flags, rsp_err<=0, rsp_id<=winner, rsp_valid<=1; go to RESP.
- RESP:
  - Hold all rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid<=0 and go to IDLE. A new grant can be given in the following cycle.
  - rsp_ready may be held high permanently.
- Latency and throughput:
  - Legal op: handshake edge to rsp_valid rising = 3 edges.
  - Minimum issue interval, with rsp_ready=1: 5 cycles.
  - Rejected op: rsp_valid rises on the handshake edge itself.
- Requester rules:
  - Request fields may change after handshake; the block uses its registered copies only.
  - A requester that drops valid before being granted loses no fairness state.
- Width rules: operands pass through unmodified. Flags and carry semantics are the ALU's; the arbiter does no arithmetic.

Decomposition:
- Package tiny16_alu_pkg holds:
  - opcode constants OP_ADD=4'd3 … OP_SHR=4'd11;
  - flag bit indices FLG_O=3, FLG_C=2, FLG_N=1, FLG_Z=0;
  - arbiter state encoding.
- Sub-module rr_arbiter (parameter NREQ): inputs req vector and last, output one-hot grant plus index; purely combinational.

Test Plan:
- Single ADD: requester 1, src1=16'h7FFF, src2=16'h0001 -> rsp after 3 edges; id=1, result=16'h8000, flags O=1, N=1, Z=0, err=0.
- Round-robin: all 4 valid every cycle, rsp_ready=1 -> grant order 0,1,2,3,0; no requester granted twice before all others.
- DIV by zero: requester 2, opcode=6, src2=0 -> rsp_valid on the handshake edge; err=1, result=0, flags=0; alu_out_en never asserted.
- Backpressure: SUB 5-7 with rsp_ready=0 for 10 cycles -> result=16'hFFFE, N=1, held stable; no new req_ready until rsp_ready is accepted.
- Illegal opcode 4'hF from requester 0, then legal XOR 16'hF0F0^16'h0FF0 from requester 3 -> first err=1; second result=16'hFF00, N=1, err=0.
- Reset asserted in OUTEN -> next cycle rsp_valid=0, alu_out_en=0, state IDLE; requester 0 wins the next arbitration.
